core_seq_ctrl: RTL and testbench
================================

# core_seq_ctrl

Parametrised stage sequencer for the multi-cycle RV32 core, generalising the fixed four-state fetch/decode/execute/writeback controller. It steps through `NUM_STAGES` stages using per-stage ready handshakes. It adds stall, flush/redirect, halt/resume at instruction boundaries, a per-stage watchdog, and a retired-instruction counter. It sits at core top level, driving stage enables and consuming stage ready signals.

## Interface
Parameters:
- `NUM_STAGES`, 4: number of sequential stages, ≥2; index 0 is fetch, `NUM_STAGES-1` retires.
- `CNT_W`, 64: width of the retired-instruction counter.
- `WDOG_W`, 8: width of the watchdog counter.
- `TIMEOUT_CYC`, 200: cycles a stage may stay active without ready; 0 disables the watchdog; must be < 2^`WDOG_W`.
- `IDX_W`, `$clog2(NUM_STAGES)`: derived; must not be overridden.

Ports:
- `clk_i`  in  1  clock. One clock; all state updates on its rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `stg_ready_i`  in  `NUM_STAGES`  per-stage done; only the bit of the active stage is sampled.
- `stall_i`  in  1  hold the current stage and block advancement.
- `flush_i`  in  1  abort the current instruction and return to stage 0.
- `halt_req_i`  in  1  request a halt at the next retire; latched.
- `resume_i`  in  1  leave HALTED.
- `stg_en_o`  out  `NUM_STAGES`  one-hot enable of the active stage; all zero when halted.
- `stg_idx_o`  out  `IDX_W`  active stage index.
- `stg_start_o`  out  1  pulse in the first cycle a stage is active.
- `retire_o`  out  1  one-cycle pulse when the last stage has completed.
- `instret_o`  out  `CNT_W`  retired-instruction count.
- `halted_o`  out  1  high while in HALTED.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- The FSM has two modes, RUN and HALTED. In RUN, `stg_idx` ranges over 0..`NUM_STAGES`-1.
- In RUN each cycle, events are evaluated in priority order. The first match wins:
  1. `flush_i`: `stg_idx` goes to 0, `stg_start` is set, the watchdog clears, no retire.
  2. Watchdog expiry: treated as a flush and `timeout_o` pulses. It only fires if `stg_ready_i[idx]` is low that cycle.
  3. `stall_i`: hold everything; the watchdog keeps counting.
  4. `stg_ready_i[idx]` with idx below the last stage: idx+1, `stg_start` set, watchdog cleared.
  5. `stg_ready_i[last]`: `retire_o` pulses and `instret` increments, wrapping modulo 2^`CNT_W`. Then:
     - if halt is pending: go to HALTED and clear halt pending;
     - otherwise: idx goes to 0 with `stg_start` set.
- Halt pending is set by `halt_req_i` in any RUN cycle. A request in the same cycle as a retire takes effect at that retire.
- A halt request while already pending has no further effect. Flush does not clear halt pending.
- In HALTED:
  - `stg_en_o` is 0, `halted_o` is 1, the watchdog is idle;
  - `flush_i`, `stall_i`, `stg_ready_i` and `halt_req_i` are ignored;
  - `resume_i` returns to RUN with idx 0 and `stg_start` set.
- Watchdog: counts active-stage cycles in RUN and fires when the count reaches `TIMEOUT_CYC`-1. It is disabled when `TIMEOUT_CYC` is 0.

## Timing
- All outputs are registered. An event sampled in cycle N is visible in cycle N+1: new `stg_en_o`, `stg_idx_o`, `stg_start_o`, `retire_o`, `instret_o` and `timeout_o`.
- Minimum instruction period is `NUM_STAGES` cycles, with every ready high on its stage's first cycle.
- Reset values:
  - `stg_en_o` = 1 (stage 0), `stg_idx_o` = 0, `stg_start_o` = 1;
  - `retire_o` = 0, `instret_o` = 0, `halted_o` = 0, `timeout_o` = 0;
  - halt pending and watchdog cleared.
- Reset mid-instruction aborts it without a retire.
- `stg_start_o` is high for exactly one cycle per stage entry, including re-entry of stage 0 after a flush.
- `instret_o` and `retire_o` change in the same cycle.
- A stage with `stg_ready_i` high on a stall cycle does not advance. Ready must still be high once the stall drops.

## Structure
- Package `core_seq_pkg`:
  - mode enum: RUN, HALTED;
  - localparam defaults;
  - function `onehot(idx)`.
- Sub-module `seq_wdog`: the watchdog counter.
  - Parameters: `WDOG_W`, `TIMEOUT_CYC`.
  - Ports: `clk_i`, `rst_i`, `clr_i`, `cnt_en_i`, `expire_o` (combinational).
- Top level: core_seq_ctrl instantiates it and holds the FSM, halt-pending flag and `instret` counter.

## Test plan
- Reset, then ready high on each stage's first cycle with `NUM_STAGES`=4 → `stg_idx_o` 0,1,2,3,0; `retire_o` every 4th cycle; `instret_o`=3 after 12 cycles.
- Stage 2 active, `stall_i` and `stg_ready_i[2]` high for 3 cycles, then stall low → idx stays 2 for 3 cycles, advances to 3 one cycle after stall drops.
- `flush_i` and `stg_ready_i[3]` in the same cycle → idx 0, `stg_start_o`=1, `retire_o`=0, `instret_o` unchanged.
- `halt_req_i` pulsed at stage 1, then completion → `retire_o` pulse, `halted_o`=1, `stg_en_o`=0. `flush_i` is then ignored; `resume_i` → idx 0 with `stg_start_o`=1.
- `TIMEOUT_CYC`=5, stage 1 never ready → `timeout_o` pulses after 5 active cycles, idx 0, no retire. With `TIMEOUT_CYC`=0 the same stimulus hangs in stage 1.
- `CNT_W`=4, 16 retires → `instret_o` wraps 15→0; `rst_i` asserted mid-stage 2 → all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/core_seq_ctrl_pkg.sv
// Shared types, defaults and helpers for the stage sequencer.
package core_seq_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } mode_e;

  localparam int NUM_STAGES_DEF = 4;
  localparam int CNT_W_DEF      = 64;
  localparam int WDOG_W_DEF     = 8;
  localparam int TIMEOUT_DEF    = 200;

  // Widest stage vector onehot() can build; NUM_STAGES must not exceed it.
  localparam int MAX_STAGES     = 32;

  function automatic logic [MAX_STAGES-1:0] onehot(input int unsigned idx);
    return MAX_STAGES'(1) << idx;
  endfunction

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Stage handshake bundle between the sequencer (master) and the core stages (slave).
interface core_seq_ctrl_if #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 64
);
  localparam int IDX_W = $clog2(NUM_STAGES);

  logic [NUM_STAGES-1:0] stg_ready_i;
  logic                  stall_i;
  logic                  flush_i;
  logic                  halt_req_i;
  logic                  resume_i;
  logic [NUM_STAGES-1:0] stg_en_o;
  logic [IDX_W-1:0]      stg_idx_o;
  logic                  stg_start_o;
  logic                  retire_o;
  logic [CNT_W-1:0]      instret_o;
  logic                  halted_o;
  logic                  timeout_o;

  modport master (
    input  stg_ready_i, stall_i, flush_i, halt_req_i, resume_i,
    output stg_en_o, stg_idx_o, stg_start_o, retire_o, instret_o, halted_o, timeout_o
  );

  modport slave (
    output stg_ready_i, stall_i, flush_i, halt_req_i, resume_i,
    input  stg_en_o, stg_idx_o, stg_start_o, retire_o, instret_o, halted_o, timeout_o
  );
endinterface

// File: rtl/core_seq_ctrl_wdog.sv
// Per-stage watchdog: counts cycles a stage stays active, flags expiry.
module seq_wdog #(
  parameter int WDOG_W      = 8,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic expire_o
);
  localparam logic              EN    = (TIMEOUT_CYC != 0);
  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  logic [WDOG_W-1:0] cnt_q;

  // Saturate at the limit so a stalled-but-ready stage still expires
  // the moment its ready drops, instead of wrapping past the threshold.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i)                   cnt_q <= '0;
    else if (EN && cnt_en_i && !expire_o) cnt_q <= cnt_q + 1'b1;
  end

  assign expire_o = EN && (cnt_q >= LIMIT);
endmodule

// File: rtl/core_seq_ctrl.sv
// Parametrised stage sequencer: stall, flush, halt/resume, watchdog, instret.
module core_seq_ctrl
  import core_seq_pkg::*;
#(
  parameter int NUM_STAGES  = NUM_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WDOG_W      = WDOG_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int IDX_W       = $clog2(NUM_STAGES)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  core_seq_ctrl_if.master bus
);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_STAGES - 1);
  localparam int               PAD_W = 2 ** IDX_W;

  mode_e                 mode_q, mode_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] en_q, en_d;
  logic                  start_q, start_d;
  logic                  retire_q, retire_d;
  logic                  tmo_q, tmo_d;
  logic                  pend_q, pend_d;
  logic [CNT_W-1:0]      instret_q, instret_d;
  logic                  wd_clr, wd_en, wd_exp;
  logic [PAD_W-1:0]      rdy_pad;
  logic                  rdy;

  // Pad ready to a power of two so any idx value is a legal select.
  assign rdy_pad = PAD_W'(bus.stg_ready_i);
  assign rdy     = rdy_pad[idx_q];

  seq_wdog #(
    .WDOG_W      (WDOG_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (wd_clr),
    .cnt_en_i (wd_en),
    .expire_o (wd_exp)
  );

  // Next-state: prioritised RUN events, resume out of HALTED.
  always_comb begin
    mode_d    = mode_q;
    idx_d     = idx_q;
    start_d   = 1'b0;
    retire_d  = 1'b0;
    tmo_d     = 1'b0;
    pend_d    = pend_q;
    instret_d = instret_q;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;
    case (mode_q)
      RUN: begin
        wd_en  = 1'b1;
        pend_d = pend_q | bus.halt_req_i;
        if (bus.flush_i) begin
          idx_d   = '0;
          start_d = 1'b1;
          wd_clr  = 1'b1;
        end else if (wd_exp && !rdy) begin
          idx_d   = '0;
          start_d = 1'b1;
          wd_clr  = 1'b1;
          tmo_d   = 1'b1;
        end else if (bus.stall_i) begin
          // hold; watchdog keeps counting
        end else if (rdy) begin
          wd_clr = 1'b1;
          if (idx_q != LAST) begin
            idx_d   = idx_q + 1'b1;
            start_d = 1'b1;
          end else begin
            retire_d  = 1'b1;
            instret_d = instret_q + 1'b1;
            idx_d     = '0;
            // A request arriving on the retire cycle itself halts here.
            if (pend_d) begin
              mode_d = HALTED;
              pend_d = 1'b0;
            end else begin
              start_d = 1'b1;
            end
          end
        end
      end
      HALTED: begin
        wd_clr = 1'b1;
        if (bus.resume_i) begin
          mode_d  = RUN;
          idx_d   = '0;
          start_d = 1'b1;
        end
      end
    endcase
    en_d = (mode_d == HALTED) ? '0 : NUM_STAGES'(onehot(32'(idx_d)));
  end

  // State and registered outputs; reset lands on stage 0 entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q    <= RUN;
      idx_q     <= '0;
      en_q      <= NUM_STAGES'(1);
      start_q   <= 1'b1;
      retire_q  <= 1'b0;
      tmo_q     <= 1'b0;
      pend_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      en_q      <= en_d;
      start_q   <= start_d;
      retire_q  <= retire_d;
      tmo_q     <= tmo_d;
      pend_q    <= pend_d;
      instret_q <= instret_d;
    end
  end

  assign bus.stg_en_o    = en_q;
  assign bus.stg_idx_o   = idx_q;
  assign bus.stg_start_o = start_q;
  assign bus.retire_o    = retire_q;
  assign bus.instret_o   = instret_q;
  assign bus.halted_o    = (mode_q == HALTED);
  assign bus.timeout_o   = tmo_q;
endmodule

// File: tb/tb_core_seq_ctrl.sv
// Two sequencer configurations driven by shared stimulus against a cycle model.
module tb_core_seq_ctrl;
  localparam int NS_A = 4, CW_A = 4,  TC_A = 5;
  localparam int NS_B = 3, CW_B = 16, TC_B = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rdy;
  logic       stall, flush, hreq, resume;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  core_seq_ctrl_if #(.NUM_STAGES(NS_A), .CNT_W(CW_A)) ifa ();
  core_seq_ctrl_if #(.NUM_STAGES(NS_B), .CNT_W(CW_B)) ifb ();

  assign ifa.stg_ready_i = rdy;
  assign ifa.stall_i     = stall;
  assign ifa.flush_i     = flush;
  assign ifa.halt_req_i  = hreq;
  assign ifa.resume_i    = resume;
  assign ifb.stg_ready_i = rdy[2:0];
  assign ifb.stall_i     = stall;
  assign ifb.flush_i     = flush;
  assign ifb.halt_req_i  = hreq;
  assign ifb.resume_i    = resume;

  core_seq_ctrl #(.NUM_STAGES(NS_A), .CNT_W(CW_A), .WDOG_W(8), .TIMEOUT_CYC(TC_A))
    u_dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
  core_seq_ctrl #(.NUM_STAGES(NS_B), .CNT_W(CW_B), .WDOG_W(4), .TIMEOUT_CYC(TC_B))
    u_dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));

  // Reference model: stage number, cycles spent in the stage, retire count.
  int      m_stage [2];
  int      m_age   [2];
  bit      m_halt  [2];
  bit      m_pend  [2];
  longint  m_cnt   [2];
  bit      e_start [2];
  bit      e_ret   [2];
  bit      e_tmo   [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic mstep(input int k, input int ns, input int tc, input int cw);
    bit r;
    r = rdy[m_stage[k]];
    e_start[k] = 0; e_ret[k] = 0; e_tmo[k] = 0;
    if (rst) begin
      m_stage[k] = 0; m_age[k] = 0; m_halt[k] = 0; m_pend[k] = 0;
      m_cnt[k] = 0; e_start[k] = 1;
      return;
    end
    if (m_halt[k]) begin
      if (resume) begin
        m_halt[k] = 0; m_stage[k] = 0; m_age[k] = 0; e_start[k] = 1;
      end
      return;
    end
    if (hreq) m_pend[k] = 1;
    if (flush) begin
      m_stage[k] = 0; m_age[k] = 0; e_start[k] = 1;
    end else if (tc != 0 && m_age[k] + 1 >= tc && !r) begin
      m_stage[k] = 0; m_age[k] = 0; e_start[k] = 1; e_tmo[k] = 1;
    end else if (stall || !r) begin
      m_age[k]++;
    end else begin
      m_age[k] = 0;
      if (m_stage[k] < ns - 1) begin
        m_stage[k]++; e_start[k] = 1;
      end else begin
        e_ret[k] = 1;
        m_cnt[k] = (m_cnt[k] + 1) % (longint'(1) << cw);
        m_stage[k] = 0;
        if (m_pend[k]) begin m_halt[k] = 1; m_pend[k] = 0; end
        else e_start[k] = 1;
      end
    end
  endtask

  task automatic chk_a();
    chk("a_en",     64'(ifa.stg_en_o),    m_halt[0] ? 64'd0 : (64'd1 << m_stage[0]));
    chk("a_idx",    64'(ifa.stg_idx_o),   64'(m_stage[0]));
    chk("a_start",  64'(ifa.stg_start_o), 64'(e_start[0]));
    chk("a_retire", 64'(ifa.retire_o),    64'(e_ret[0]));
    chk("a_instret",64'(ifa.instret_o),   64'(m_cnt[0]));
    chk("a_halted", 64'(ifa.halted_o),    64'(m_halt[0]));
    chk("a_tmo",    64'(ifa.timeout_o),   64'(e_tmo[0]));
  endtask

  task automatic chk_b();
    chk("b_en",     64'(ifb.stg_en_o),    m_halt[1] ? 64'd0 : (64'd1 << m_stage[1]));
    chk("b_idx",    64'(ifb.stg_idx_o),   64'(m_stage[1]));
    chk("b_start",  64'(ifb.stg_start_o), 64'(e_start[1]));
    chk("b_retire", 64'(ifb.retire_o),    64'(e_ret[1]));
    chk("b_instret",64'(ifb.instret_o),   64'(m_cnt[1]));
    chk("b_halted", 64'(ifb.halted_o),    64'(m_halt[1]));
    chk("b_tmo",    64'(ifb.timeout_o),   64'(e_tmo[1]));
  endtask

  // Hold one input set for n cycles, checking both DUTs every cycle.
  task automatic drv(input logic [3:0] r, input bit st, input bit fl, input bit hr,
                     input bit rs, input bit rt, input int n);
    for (int i = 0; i < n; i++) begin
      rdy = r; stall = st; flush = fl; hreq = hr; resume = rs; rst = rt;
      @(posedge clk);
      mstep(0, NS_A, TC_A, CW_A);
      mstep(1, NS_B, TC_B, CW_B);
      @(negedge clk);
      chk_a();
      chk_b();
    end
  endtask

  initial begin
    rdy = '0; stall = 0; flush = 0; hreq = 0; resume = 0; rst = 1;
    drv(4'h0, 0, 0, 0, 0, 1, 2);
    chk("rst_en",    64'(ifa.stg_en_o), 64'd1);
    chk("rst_start", 64'(ifa.stg_start_o), 64'd1);
    // full-speed pipeline: 3 retires in 12 cycles
    drv(4'hf, 0, 0, 0, 0, 0, 12);
    chk("instret12", 64'(ifa.instret_o), 64'd3);
    // stall on stage 2 with ready held
    drv(4'hf, 0, 0, 0, 0, 0, 2);
    drv(4'h4, 1, 0, 0, 0, 0, 3);
    chk("stall_idx", 64'(ifa.stg_idx_o), 64'd2);
    drv(4'h4, 0, 0, 0, 0, 0, 1);
    chk("post_stall_idx", 64'(ifa.stg_idx_o), 64'd3);
    // flush beats last-stage ready
    drv(4'h8, 0, 1, 0, 0, 0, 1);
    chk("flush_idx", 64'(ifa.stg_idx_o), 64'd0);
    // halt requested at stage 1, completes at retire
    drv(4'h1, 0, 0, 0, 0, 0, 1);
    drv(4'h2, 0, 0, 1, 0, 0, 1);
    drv(4'hf, 0, 0, 0, 0, 0, 2);
    chk("halted", 64'(ifa.halted_o), 64'd1);
    drv(4'hf, 1, 1, 1, 0, 0, 3);
    drv(4'h0, 0, 0, 0, 1, 0, 1);
    chk("resume_start", 64'(ifa.stg_start_o), 64'd1);
    // watchdog on stage 1 (A fires, B hangs)
    drv(4'h1, 0, 0, 0, 0, 0, 1);
    drv(4'h0, 0, 0, 0, 0, 0, 8);
    // reset mid stage 2
    drv(4'hf, 0, 0, 0, 0, 0, 2);
    drv(4'h0, 0, 0, 0, 0, 1, 1);
    drv(4'h0, 0, 0, 0, 0, 0, 1);
    // random traffic
    for (int i = 0; i < 4000; i++)
      drv(4'($urandom), ($urandom % 8) == 0, ($urandom % 24) == 0, ($urandom % 16) == 0,
          ($urandom % 4) == 0, ($urandom % 300) == 0, 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
